// File: rtl/elastic_config_loader.sv
// Elastic configuration loader: turns a SELF-handshaked host stream of LOAD/START packets into PE context writes.
// Define CONFIG_LOADER_CHECKSUM_EN to require a trailing XOR checksum word on every LOAD packet.

module elastic_config_loader #(
  parameter int PE_NUM                  = 16,
  parameter int CONTEXT_SIZE            = 16,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int INPUT_NUM_BIT_LENGTH    = 3,
  parameter int NEIGHBOR_PE_NUM         = 4,
  parameter int OPERATION_BIT_LENGTH    = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DATA_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic                               in_stop,
  input  logic                               clear_error,
  output logic [PE_NUM-1:0]                  config_pe_select,
  output logic                               write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               error
);

  localparam int CTX_W = CONTEXT_SIZE_BIT_LENGTH;
  localparam int SEL_W = INPUT_NUM_BIT_LENGTH;
  localparam int OE_W  = NEIGHBOR_PE_NUM;
  localparam int OP_W  = OPERATION_BIT_LENGTH;

  localparam logic [7:0]  OPC_LOAD  = 8'h01;
  localparam logic [7:0]  OPC_START = 8'h02;
  localparam logic [31:0] PE_LIMIT  = PE_NUM;
  localparam logic [31:0] CTX_LIMIT = CONTEXT_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    CONST,
    WRITE,
    START
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CTX_W-1:0]   counter_q, counter_d;
  logic [CTX_W-1:0]   last_q, last_d;
  logic [CTX_W-1:0]   max_id_q, max_id_d;
  logic [CTX_W-1:0]   map_max_q, map_max_d;
  logic [CTX_W-1:0]   cfg_index_q, cfg_index_d;
  logic [7:0]         pe_id_q, pe_id_d;
  logic [PE_NUM-1:0]  pe_sel_q, pe_sel_d;
  logic [SEL_W-1:0]   idx1_q, idx1_d;
  logic [SEL_W-1:0]   idx2_q, idx2_d;
  logic [OE_W-1:0]    oe_q, oe_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_WIDTH-1:0] const_q, const_d;
  logic               error_q, error_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic       accept;
  logic       set_error;
  logic [7:0] hdr_opc, hdr_pe, hdr_last, hdr_max;
  logic       load_ok, start_ok;

  // Header fields sit at fixed byte positions of the low 32 bits of the word.
  assign hdr_opc  = in_data[31:24];
  assign hdr_pe   = in_data[23:16];
  assign hdr_last = in_data[15:8];
  assign hdr_max  = in_data[7:0];

  assign load_ok  = (hdr_opc == OPC_LOAD) && ({24'd0, hdr_pe} < PE_LIMIT)
                    && ({24'd0, hdr_last} < CTX_LIMIT);
  assign start_ok = (hdr_opc == OPC_START) && ({24'd0, hdr_max} < CTX_LIMIT);

  assign accept = in_valid && !in_stop;

  // NOTE: every _d gets its hold value before the case so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    last_d      = last_q;
    max_id_d    = max_id_q;
    map_max_d   = map_max_q;
    cfg_index_d = cfg_index_q;
    pe_id_d     = pe_id_q;
    pe_sel_d    = pe_sel_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    oe_d        = oe_q;
    op_d        = op_q;
    const_d     = const_q;
    set_error   = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (load_ok) begin
            pe_id_d   = hdr_pe;
            last_d    = hdr_last[CTX_W-1:0];
            counter_d = '0;
            state_d   = CTRL;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum_d    = in_data;
`endif
          end else if (start_ok) begin
            max_id_d = hdr_max[CTX_W-1:0];
            state_d  = START;
          end else begin
            set_error = 1'b1;
          end
        end
      end

      CTRL: begin
        if (accept) begin
          idx1_d  = in_data[0 +: SEL_W];
          idx2_d  = in_data[SEL_W +: SEL_W];
          oe_d    = in_data[2*SEL_W +: OE_W];
          op_d    = in_data[2*SEL_W+OE_W +: OP_W];
          state_d = CONST;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
        end
      end

      CONST: begin
        if (accept) begin
          const_d     = in_data;
          cfg_index_d = counter_q;
          for (int i = 0; i < PE_NUM; i++) begin
            pe_sel_d[i] = (pe_id_q == 8'(i));
          end
          state_d     = WRITE;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
        end
      end

      WRITE: begin
        if (counter_q == last_q) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = IDLE;
`endif
        end else begin
          counter_d = counter_q + CTX_W'(1);
          state_d   = CTRL;
        end
      end

      START: begin
        if (!error_q) begin
          map_max_d = max_id_q;
        end
        state_d = IDLE;
      end

`ifdef CONFIG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (in_data != csum_q) begin
            set_error = 1'b1;
          end
          state_d = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    // A same-cycle error event beats clear_error.
    error_d = error_q;
    if (clear_error) error_d = 1'b0;
    if (set_error)   error_d = 1'b1;
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      last_q      <= '0;
      max_id_q    <= '0;
      map_max_q   <= '0;
      cfg_index_q <= '0;
      pe_id_q     <= '0;
      pe_sel_q    <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      oe_q        <= '0;
      op_q        <= '0;
      const_q     <= '0;
      error_q     <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      last_q      <= last_d;
      max_id_q    <= max_id_d;
      map_max_q   <= map_max_d;
      cfg_index_q <= cfg_index_d;
      pe_id_q     <= pe_id_d;
      pe_sel_q    <= pe_sel_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      oe_q        <= oe_d;
      op_q        <= op_d;
      const_q     <= const_d;
      error_q     <= error_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Stall is also raised while reset is held so the host cannot push into a block that is not running.
  assign in_stop                 = !reset_n || (state_q == WRITE) || (state_q == START);
  assign busy                    = (state_q != IDLE);
  assign write_config_data       = (state_q == WRITE);
  assign start_exec              = (state_q == START) && !error_q;
  assign config_pe_select        = pe_sel_q;
  assign config_index            = cfg_index_q;
  assign config_input_PE_index_1 = idx1_q;
  assign config_input_PE_index_2 = idx2_q;
  assign config_output_PE_index  = oe_q;
  assign config_op               = op_q;
  assign config_const_data       = const_q;
  assign mapping_context_max_id  = map_max_q;
  assign error                   = error_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Self-checking bench for elastic_config_loader: directed packets plus random traffic against a word-level model.
// Build with +define+CONFIG_LOADER_CHECKSUM_EN to exercise the checksum variant.

module tb_elastic_config_loader;

  localparam int PE_NUM = 16;
  localparam int CTX    = 16;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        clear_error = 1'b0;
  logic        in_stop;
  logic [15:0] config_pe_select;
  logic        write_config_data;
  logic [3:0]  config_index;
  logic [2:0]  config_input_PE_index_1;
  logic [2:0]  config_input_PE_index_2;
  logic [3:0]  config_output_PE_index;
  logic [4:0]  config_op;
  logic [31:0] config_const_data;
  logic        start_exec;
  logic [3:0]  mapping_context_max_id;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  elastic_config_loader dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .in_data                 (in_data),
    .in_valid                (in_valid),
    .in_stop                 (in_stop),
    .clear_error             (clear_error),
    .config_pe_select        (config_pe_select),
    .write_config_data       (write_config_data),
    .config_index            (config_index),
    .config_input_PE_index_1 (config_input_PE_index_1),
    .config_input_PE_index_2 (config_input_PE_index_2),
    .config_output_PE_index  (config_output_PE_index),
    .config_op               (config_op),
    .config_const_data       (config_const_data),
    .start_exec              (start_exec),
    .mapping_context_max_id  (mapping_context_max_id),
    .busy                    (busy),
    .error                   (error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] pe_sel;
    logic [3:0]  idx;
    logic [2:0]  idx1;
    logic [2:0]  idx2;
    logic [3:0]  oe;
    logic [4:0]  op;
    logic [31:0] cdata;
  } wr_t;

  wr_t wlog[$];
  int  n_start = 0;
  int  n_stop  = 0;

  // Word-level model: tracks where the stream is inside a packet and which cycles the DUT owes a stall.
  bit          m_stall, m_in_pkt, m_wr, m_startc, m_err;
  logic [3:0]  m_map, m_max;
  int          m_pe, m_last, m_beat;
  logic [31:0] m_ctrl, m_csum;
  int          m_w_pe, m_w_idx;
  logic [31:0] m_w_ctrl, m_w_const;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_stall = 0; m_in_pkt = 0; m_wr = 0; m_startc = 0; m_err = 0;
      m_map = '0; m_max = '0; m_pe = 0; m_last = 0; m_beat = 0;
      m_ctrl = '0; m_csum = '0;
    end else begin
      logic [15:0] e_sel;
      bit acc, n_stall, n_wr, n_startc, set_e;
      check("in_stop", 32'(in_stop), 32'(m_stall));
      check("busy", 32'(busy), 32'(m_in_pkt | m_stall));
      check("write_config_data", 32'(write_config_data), 32'(m_wr));
      check("start_exec", 32'(start_exec), 32'(m_startc && !m_err));
      check("error", 32'(error), 32'(m_err));
      check("mapping_context_max_id", 32'(mapping_context_max_id), 32'(m_map));
      if (write_config_data)
        wlog.push_back('{config_pe_select, config_index, config_input_PE_index_1,
                         config_input_PE_index_2, config_output_PE_index, config_op,
                         config_const_data});
      if (start_exec) n_start++;
      if (in_stop) n_stop++;
      if (m_wr) begin
        e_sel = '0;
        e_sel[m_w_pe] = 1'b1;
        check("config_pe_select", 32'(config_pe_select), 32'(e_sel));
        check("config_index", 32'(config_index), 32'(m_w_idx));
        check("idx1", 32'(config_input_PE_index_1), 32'(m_w_ctrl[2:0]));
        check("idx2", 32'(config_input_PE_index_2), 32'(m_w_ctrl[5:3]));
        check("out_en", 32'(config_output_PE_index), 32'(m_w_ctrl[9:6]));
        check("op", 32'(config_op), 32'(m_w_ctrl[14:10]));
        check("const", config_const_data, m_w_const);
      end

      acc = in_valid && !m_stall;
      n_stall = 0; n_wr = 0; n_startc = 0; set_e = 0;
      if (m_startc && !m_err) m_map = m_max;
      if (acc) begin
        if (!m_in_pkt) begin
          if (in_data[31:24] == 8'h01 && int'(in_data[23:16]) < PE_NUM && int'(in_data[15:8]) < CTX) begin
            m_in_pkt = 1; m_pe = int'(in_data[23:16]); m_last = int'(in_data[15:8]);
            m_beat = 0; m_csum = in_data;
          end else if (in_data[31:24] == 8'h02 && int'(in_data[7:0]) < CTX) begin
            m_max = in_data[3:0]; n_stall = 1; n_startc = 1;
          end else begin
            set_e = 1;
          end
        end else if (m_beat < 2 * (m_last + 1)) begin
          m_csum = m_csum ^ in_data;
          if (m_beat % 2 == 0) begin
            m_ctrl = in_data;
          end else begin
            m_w_pe = m_pe; m_w_idx = m_beat / 2; m_w_ctrl = m_ctrl; m_w_const = in_data;
            n_wr = 1; n_stall = 1;
            if (m_beat == 2 * m_last + 1 && !CSUM_EN) m_in_pkt = 0;
          end
          m_beat++;
        end else begin
          if (in_data != m_csum) set_e = 1;
          m_in_pkt = 0;
        end
      end
      if (set_e) m_err = 1;
      else if (clear_error) m_err = 0;
      m_stall = n_stall; m_wr = n_wr; m_startc = n_startc;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [31:0] w, input bit gaps);
    bit done;
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    in_valid = 1'b1;
    in_data  = w;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = !in_stop;
      @(posedge clk); #1;
    end
    check("send_accepted", 32'(done), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic send_load(input int pe, input int last, input bit gaps, input bit bad_csum,
                           input logic [31:0] c0, input logic [31:0] k0);
    logic [31:0] hdr, c, k, csum;
    hdr  = {8'h01, 8'(pe), 8'(last), 8'($urandom)};
    csum = hdr;
    send(hdr, gaps);
    for (int i = 0; i <= last; i++) begin
      c = (i == 0) ? c0 : $urandom;
      k = (i == 0) ? k0 : $urandom;
      send(c, gaps);
      send(k, gaps);
      csum = csum ^ c ^ k;
    end
    if (CSUM_EN) send(csum ^ {31'd0, bad_csum}, gaps);
  endtask

  task automatic send_start(input int max_id, input bit gaps);
    send({8'h02, 16'($urandom), 8'(max_id)}, gaps);
  endtask

  task automatic pulse_clear();
    clear_error = 1'b1;
    @(posedge clk); #1;
    clear_error = 1'b0;
  endtask

  task automatic send_bad(input int kind);
    logic [7:0] opc;
    case (kind)
      0: begin
        opc = 8'($urandom_range(3, 255));
        send({opc, 24'($urandom)}, 1);
      end
      1: send({8'h01, 8'($urandom_range(PE_NUM, 255)), 8'($urandom_range(0, CTX - 1)), 8'h00}, 1);
      2: send({8'h01, 8'($urandom_range(0, PE_NUM - 1)), 8'($urandom_range(CTX, 255)), 8'h00}, 1);
      default: send_start($urandom_range(CTX, 255), 1);
    endcase
  endtask

  initial begin
    int base, s0, st0;
    // Reset state, sampled while reset is still asserted.
    #1;
    check("rst_in_stop", 32'(in_stop), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_write", 32'(write_config_data), 32'(0));
    check("rst_pe_select", 32'(config_pe_select), 32'(0));
    check("rst_start_exec", 32'(start_exec), 32'(0));
    check("rst_error", 32'(error), 32'(0));
    check("rst_max_id", 32'(mapping_context_max_id), 32'(0));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // LOAD pe 2, single record.
    send_load(2, 0, 0, 0, 32'h0000_0009, 32'h0000_0005);
    idle(3);
    check("t1_writes", 32'(wlog.size()), 32'(1));
    if (wlog.size() >= 1) begin
      check("t1_pe_select", 32'(wlog[0].pe_sel), 32'h0004);
      check("t1_index", 32'(wlog[0].idx), 32'd0);
      check("t1_idx1", 32'(wlog[0].idx1), 32'd1);
      check("t1_idx2", 32'(wlog[0].idx2), 32'd1);
      check("t1_const", wlog[0].cdata, 32'd5);
    end

    // LOAD pe 0, three records, in_valid held high.
    base = wlog.size();
    st0  = n_stop;
    send_load(0, 2, 0, 0, $urandom, $urandom);
    idle(3);
    check("t2_writes", 32'(wlog.size() - base), 32'd3);
    check("t2_stop_cycles", 32'(n_stop - st0), 32'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < wlog.size()) check("t2_index", 32'(wlog[base+i].idx), 32'(i));

    // START max_id 3.
    s0 = n_start;
    send_start(3, 0);
    idle(2);
    check("t3_pulses", 32'(n_start - s0), 32'd1);
    check("t3_max_id", 32'(mapping_context_max_id), 32'd3);

    // Bad opcode blocks the next START until cleared.
    s0 = n_start;
    send(32'h0700_0000, 0);
    send_start(1, 0);
    idle(2);
    check("t4_error", 32'(error), 32'd1);
    check("t4_no_pulse", 32'(n_start - s0), 32'd0);
    check("t4_max_kept", 32'(mapping_context_max_id), 32'd3);
    pulse_clear();
    check("t4_cleared", 32'(error), 32'd0);
    send_start(1, 0);
    idle(2);
    check("t4_pulse", 32'(n_start - s0), 32'd1);
    check("t4_max_id", 32'(mapping_context_max_id), 32'd1);

    // Header boundaries.
    send({8'h01, 8'd16, 8'd0, 8'd0}, 0);
    idle(1);
    check("b_pe16_error", 32'(error), 32'd1);
    pulse_clear();
    base = wlog.size();
    send_load(15, 15, 1, 0, $urandom, $urandom);
    idle(2);
    check("b_last15_writes", 32'(wlog.size() - base), 32'd16);
    check("b_last15_noerr", 32'(error), 32'd0);
    send_start(16, 0);
    idle(1);
    check("b_max16_error", 32'(error), 32'd1);
    pulse_clear();
    send_start(15, 0);
    idle(2);
    check("b_max15", 32'(mapping_context_max_id), 32'd15);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    base = wlog.size();
    send_load(3, 1, 0, 1, $urandom, $urandom);
    idle(2);
    check("cs_writes", 32'(wlog.size() - base), 32'd2);
    check("cs_error", 32'(error), 32'd1);
    pulse_clear();
`endif

    // Reset after the CTRL beat of a pe 1 packet.
    base = wlog.size();
    send({8'h01, 8'd1, 8'd0, 8'd0}, 0);
    send(32'h0000_7fff, 0);
    #2 reset_n = 1'b0;
    #1;
    check("r_in_stop", 32'(in_stop), 32'd1);
    check("r_busy", 32'(busy), 32'd0);
    check("r_idx1", 32'(config_input_PE_index_1), 32'd0);
    check("r_op", 32'(config_op), 32'd0);
    check("r_pe_select", 32'(config_pe_select), 32'd0);
    check("r_const", config_const_data, 32'd0);
    check("r_max_id", 32'(mapping_context_max_id), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    idle(4);
    check("r_no_write", 32'(wlog.size()), 32'(base));

    // Random traffic.
    for (int p = 0; p < 250; p++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: send_load($urandom_range(0, PE_NUM - 1),
                                 ($urandom_range(0, 7) == 0) ? CTX - 1 : $urandom_range(0, 3),
                                 1, 0, $urandom, $urandom);
        5, 6: send_start($urandom_range(0, CTX - 1), 1);
        7: send_bad($urandom_range(0, 3));
        8: pulse_clear();
        default: send_load($urandom_range(0, PE_NUM - 1), $urandom_range(0, 2), 1, 1,
                           $urandom, $urandom);
      endcase
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
